// File: rtl/dest_reg_tracker.sv
// Decodes the ID instruction's destination register and carries its tag through
// IDEX, EXMEM, MEMWB and a post-writeback slot; stall/flush insert bubbles at the front only.
module dest_reg_tracker #(
  parameter int REG_W     = 3,
  parameter int INSTR_W   = 16,
  parameter int MAX_STALL = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               instrValid,
  input  logic               Stall,
  input  logic               flush,
  output logic [REG_W-1:0]   rd,
  output logic               rdValid,
  output logic [REG_W-1:0]   rdIDEX,
  output logic [REG_W-1:0]   rdEXMEM,
  output logic [REG_W-1:0]   rdMEMWB,
  output logic [REG_W-1:0]   rdStall,
  output logic               vIDEX,
  output logic               vEXMEM,
  output logic               vMEMWB,
  output logic               vStall,
  output logic [7:0]         stallCount,
  output logic               stallTimeout
);

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] tag;
  } tag_t;

  localparam tag_t       BUBBLE      = '0;
  localparam logic [7:0] MAX_STALL_C = 8'(MAX_STALL);

  logic [4:0]       opcode;
  logic [REG_W-1:0] dec_rd;
  logic             dec_wr;
  logic             unused_instr;

  tag_t       idex_q, idex_d;
  tag_t       exmem_q, exmem_d;
  tag_t       memwb_q, memwb_d;
  tag_t       stall_q, stall_d;
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;

  assign opcode       = instruction[15:11];
  assign unused_instr = ^instruction;

  always_comb begin
    dec_rd = '0;
    dec_wr = 1'b1;
    case (opcode)
      5'b11011, 5'b11010, 5'b11100, 5'b11101,
      5'b11110, 5'b11111, 5'b11001:
        dec_rd = REG_W'(instruction[4:2]);
      5'b01000, 5'b01001, 5'b01010, 5'b01011,
      5'b10100, 5'b10101, 5'b10110, 5'b10111, 5'b10001:
        dec_rd = REG_W'(instruction[7:5]);
      5'b10011, 5'b11000, 5'b10010:
        dec_rd = REG_W'(instruction[10:8]);
      5'b00110, 5'b00111:
        dec_rd = {REG_W{1'b1}};
      default:
        dec_wr = 1'b0;
    endcase
  end

  assign rdValid = instrValid & dec_wr;
  assign rd      = rdValid ? dec_rd : '0;

  // Older stages always advance; flush additionally kills the instruction leaving IDEX.
  always_comb begin
    idex_d  = (flush || Stall) ? BUBBLE : tag_t'{v: rdValid, tag: rd};
    exmem_d = flush ? BUBBLE : idex_q;
    memwb_d = exmem_q;
    stall_d = memwb_q;
    if (Stall && !flush)
      cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    else
      cnt_d = 8'd0;
    timeout_d = (cnt_q > MAX_STALL_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q    <= BUBBLE;
      exmem_q   <= BUBBLE;
      memwb_q   <= BUBBLE;
      stall_q   <= BUBBLE;
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      idex_q    <= idex_d;
      exmem_q   <= exmem_d;
      memwb_q   <= memwb_d;
      stall_q   <= stall_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign rdIDEX       = idex_q.tag;
  assign rdEXMEM      = exmem_q.tag;
  assign rdMEMWB      = memwb_q.tag;
  assign rdStall      = stall_q.tag;
  assign vIDEX        = idex_q.v;
  assign vEXMEM       = exmem_q.v;
  assign vMEMWB       = memwb_q.v;
  assign vStall       = stall_q.v;
  assign stallCount   = cnt_q;
  assign stallTimeout = timeout_q;

endmodule

// File: tb/tb_dest_reg_tracker.sv
// Bench for dest_reg_tracker: decode table, directed pipeline sequences, random run vs model.
module tb_dest_reg_tracker;
  localparam int MAX_STALL = 4;

  logic        clk = 1'b0;
  logic        rst, instrValid, Stall, flush;
  logic [15:0] instruction;
  logic [2:0]  rd, rdIDEX, rdEXMEM, rdMEMWB, rdStall;
  logic        rdValid, vIDEX, vEXMEM, vMEMWB, vStall, stallTimeout;
  logic [7:0]  stallCount;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference pipeline: index 0 = IDEX ... 3 = post-writeback slot
  logic       mv[4];
  logic [2:0] mt[4];
  int         mcnt;
  logic       mto;

  typedef struct {
    logic [15:0] ins;
    logic        iv;
    logic [2:0]  erd;
    logic        ev;
  } dvec_t;
  dvec_t tbl[15];

  dest_reg_tracker #(.REG_W(3), .INSTR_W(16), .MAX_STALL(MAX_STALL)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .instrValid(instrValid),
    .Stall(Stall), .flush(flush), .rd(rd), .rdValid(rdValid),
    .rdIDEX(rdIDEX), .rdEXMEM(rdEXMEM), .rdMEMWB(rdMEMWB), .rdStall(rdStall),
    .vIDEX(vIDEX), .vEXMEM(vEXMEM), .vMEMWB(vMEMWB), .vStall(vStall),
    .stallCount(stallCount), .stallTimeout(stallTimeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Destination from opcode groups, computed arithmetically from the opcode number.
  function automatic void mdecode(input logic [15:0] ins, input logic iv,
                                  output logic [2:0] r, output logic v);
    int op, lsb;
    op  = int'(ins[15:11]);
    lsb = -1;
    r   = 3'd0;
    v   = 1'b0;
    if (op == 25 || op == 26 || op >= 27)                                lsb = 2;
    else if ((op >= 8 && op <= 11) || (op >= 20 && op <= 23) || op == 17) lsb = 5;
    else if (op == 18 || op == 19 || op == 24)                            lsb = 8;
    if (iv && (op == 6 || op == 7)) begin
      r = 3'd7;
      v = 1'b1;
    end else if (iv && lsb >= 0) begin
      r = 3'((int'(ins) >> lsb) & 7);
      v = 1'b1;
    end
  endfunction

  task automatic set_in(input logic [15:0] ins, input logic iv, input logic st,
                        input logic fl, input logic r);
    instruction = ins;
    instrValid  = iv;
    Stall       = st;
    flush       = fl;
    rst         = r;
  endtask

  task automatic tick();
    logic [2:0] r;
    logic       v;
    #1;
    mdecode(instruction, instrValid, r, v);
    chk("rd", 32'(rd), 32'(r));
    chk("rdValid", 32'(rdValid), 32'(v));
    if (rst) begin
      for (int i = 0; i < 4; i++) begin mv[i] = 1'b0; mt[i] = 3'd0; end
      mcnt = 0;
      mto  = 1'b0;
    end else begin
      mto  = (mcnt > MAX_STALL);
      mcnt = (Stall && !flush) ? ((mcnt < 255) ? mcnt + 1 : 255) : 0;
      for (int i = 3; i > 0; i--) begin mv[i] = mv[i-1]; mt[i] = mt[i-1]; end
      if (flush) begin mv[1] = 1'b0; mt[1] = 3'd0; end
      if (flush || Stall) begin mv[0] = 1'b0; mt[0] = 3'd0; end
      else begin mv[0] = v; mt[0] = r; end
    end
    @(posedge clk);
    #1;
    chk("vIDEX", 32'(vIDEX), 32'(mv[0]));     chk("rdIDEX", 32'(rdIDEX), 32'(mt[0]));
    chk("vEXMEM", 32'(vEXMEM), 32'(mv[1]));   chk("rdEXMEM", 32'(rdEXMEM), 32'(mt[1]));
    chk("vMEMWB", 32'(vMEMWB), 32'(mv[2]));   chk("rdMEMWB", 32'(rdMEMWB), 32'(mt[2]));
    chk("vStall", 32'(vStall), 32'(mv[3]));   chk("rdStall", 32'(rdStall), 32'(mt[3]));
    chk("stallCount", 32'(stallCount), 32'(mcnt));
    chk("stallTimeout", 32'(stallTimeout), 32'(mto));
  endtask

  initial begin
    tbl[0]  = '{16'hD80C, 1'b1, 3'd3, 1'b1};  // add r3
    tbl[1]  = '{16'h40A0, 1'b1, 3'd5, 1'b1};  // addi r5
    tbl[2]  = '{16'hC200, 1'b1, 3'd2, 1'b1};  // lbi r2
    tbl[3]  = '{16'h3000, 1'b1, 3'd7, 1'b1};  // jal
    tbl[4]  = '{16'h3800, 1'b1, 3'd7, 1'b1};  // jalr
    tbl[5]  = '{16'h8840, 1'b1, 3'd2, 1'b1};  // ld r2
    tbl[6]  = '{16'h9E00, 1'b1, 3'd6, 1'b1};  // stu r6
    tbl[7]  = '{16'hC810, 1'b1, 3'd4, 1'b1};  // btr r4
    tbl[8]  = '{16'h9100, 1'b1, 3'd1, 1'b1};  // slbi r1
    tbl[9]  = '{16'h80FF, 1'b1, 3'd0, 1'b0};  // st
    tbl[10] = '{16'h6123, 1'b1, 3'd0, 1'b0};  // beqz
    tbl[11] = '{16'h2456, 1'b1, 3'd0, 1'b0};  // j
    tbl[12] = '{16'h0000, 1'b1, 3'd0, 1'b0};  // halt
    tbl[13] = '{16'hD80C, 1'b0, 3'd0, 1'b0};  // add, not valid
    tbl[14] = '{16'hFFFC, 1'b1, 3'd7, 1'b1};  // opcode 11111, rd in [4:2]

    // Reset held two cycles with random instruction
    set_in(16'($urandom), 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    set_in(16'($urandom), 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    chk("rst_vIDEX", 32'(vIDEX), 0);   chk("rst_vEXMEM", 32'(vEXMEM), 0);
    chk("rst_vMEMWB", 32'(vMEMWB), 0); chk("rst_vStall", 32'(vStall), 0);
    chk("rst_count", 32'(stallCount), 0);
    set_in(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("post_rst_vIDEX", 32'(vIDEX), 0);
    chk("post_rst_rdIDEX", 32'(rdIDEX), 0);

    // Decode table
    foreach (tbl[i]) begin
      set_in(tbl[i].ins, tbl[i].iv, 1'b0, 1'b0, 1'b0);
      #1;
      chk($sformatf("tbl%0d_rd", i), 32'(rd), 32'(tbl[i].erd));
      chk($sformatf("tbl%0d_v", i), 32'(rdValid), 32'(tbl[i].ev));
      tick();
    end
    set_in(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) tick();

    // Flow of add r3 through all stages
    set_in(16'hD80C, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("flow_IDEX", 32'({vIDEX, rdIDEX}), 32'({1'b1, 3'd3}));
    set_in(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); chk("flow_EXMEM", 32'({vEXMEM, rdEXMEM}), 32'({1'b1, 3'd3}));
    tick(); chk("flow_MEMWB", 32'({vMEMWB, rdMEMWB}), 32'({1'b1, 3'd3}));
    tick(); chk("flow_Stall", 32'({vStall, rdStall}), 32'({1'b1, 3'd3}));
    tick(); chk("flow_retire", 32'(vStall), 0);

    // Load-use stall for three cycles
    set_in(16'h8840, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); chk("lu_IDEX", 32'(rdIDEX), 2);
    set_in(16'hD80C, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); chk("lu1_vIDEX", 32'(vIDEX), 0); chk("lu1_EXMEM", 32'(rdEXMEM), 2);
    chk("lu1_cnt", 32'(stallCount), 1);
    tick(); chk("lu2_MEMWB", 32'(rdMEMWB), 2); chk("lu2_cnt", 32'(stallCount), 2);
    tick(); chk("lu3_Stall", 32'(rdStall), 2); chk("lu3_cnt", 32'(stallCount), 3);
    Stall = 1'b0;
    tick(); chk("lu_release", 32'({vIDEX, rdIDEX}), 32'({1'b1, 3'd3}));
    chk("lu_cnt0", 32'(stallCount), 0);

    // Flush beats stall
    set_in(16'hD80C, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    set_in(16'h8880, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    set_in(16'h4020, 1'b1, 1'b1, 1'b1, 1'b0); tick();
    chk("fl_vIDEX", 32'(vIDEX), 0); chk("fl_vEXMEM", 32'(vEXMEM), 0);
    chk("fl_MEMWB", 32'({vMEMWB, rdMEMWB}), 32'({1'b1, 3'd3}));
    chk("fl_cnt", 32'(stallCount), 0);

    // Timeout then mid-operation reset
    set_in(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("to_cnt%0d", i), 32'(stallCount), 32'(i));
      if (i == 5) chk("to_early", 32'(stallTimeout), 0);
      if (i == 6) chk("to_set", 32'(stallTimeout), 1);
    end
    rst = 1'b1;
    tick();
    chk("to_rst", 32'(stallTimeout), 0); chk("to_rst_cnt", 32'(stallCount), 0);
    chk("to_rst_v", 32'({vIDEX, vEXMEM, vMEMWB, vStall}), 0);

    // Saturation of the stall counter
    set_in(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (260) tick();
    chk("sat_cnt", 32'(stallCount), 255);
    chk("sat_to", 32'(stallTimeout), 1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      set_in(16'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 49) == 0));
      if (i % 100 == 50) begin
        Stall = 1'b1; flush = 1'b0; rst = 1'b0;
        repeat (6) tick();
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
